// File: rtl/sram_b_param_1w_nr_pkg.sv
// Shared helpers for the parametrised banked SRAM wrapper: geometry arithmetic
// and the write-over-read merge used by same-cycle forwarding.
package sram_b_pkg;

    localparam int MAXW = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 32'sd1) / b;
    endfunction

    localparam int DEF_NV = ceil_div(32'sd65536, 32'sd16384);
    localparam int DEF_NH = ceil_div(32'sd8, 32'sd1);

    // Masked bits come from the new write data, the rest keep the stored value
    function automatic logic [MAXW-1:0] bypass_merge(input logic [MAXW-1:0] wdata,
                                                     input logic [MAXW-1:0] wmask,
                                                     input logic [MAXW-1:0] old);
        return (wdata & wmask) | (old & ~wmask);
    endfunction

endpackage

// File: rtl/sram_b_param_1w_nr_if.sv
// Bus bundle between PLM logic (master) and the banked SRAM wrapper (slave).
interface sram_b_param_1w_nr_if #(
    parameter int ABITS = 16,
    parameter int DBITS = 8,
    parameter int NRD   = 2
);
    logic                  CE0;
    logic [ABITS-1:0]      A0;
    logic [DBITS-1:0]      D0;
    logic                  WE0;
    logic [DBITS-1:0]      WEM0;
    logic [NRD-1:0]        CE_R;
    logic [NRD*ABITS-1:0]  A_R;
    logic [NRD*DBITS-1:0]  Q_R;
    logic [NRD-1:0]        VALID_R;
    logic                  ERR;

    modport master (
        output CE0, A0, D0, WE0, WEM0, CE_R, A_R,
        input  Q_R, VALID_R, ERR
    );

    modport slave (
        input  CE0, A0, D0, WE0, WEM0, CE_R, A_R,
        output Q_R, VALID_R, ERR
    );
endinterface

// File: rtl/sram_b_param_1w_nr_chk.sv
// Collision checker, only instantiated when write-to-read forwarding is disabled.
module sram_b_chk #(
    parameter int ABITS = 16,
    parameter int NRD   = 2
) (
    input logic                 CLK,
    input logic                 RSTN,
    input logic                 wr_i,
    input logic [ABITS-1:0]     wr_addr_i,
    input logic [NRD-1:0]       ce_r_i,
    input logic [NRD*ABITS-1:0] a_r_i
);
    for (genvar r = 0; r < NRD; r++) begin : g_port
        // Without forwarding a same-cycle collision silently returns stale data
        a_no_collision: assert property (@(posedge CLK) disable iff (!RSTN)
            !(wr_i && ce_r_i[r] && (a_r_i[r*ABITS +: ABITS] == wr_addr_i)));
    end
endmodule

// File: rtl/sram_b_param_1w_nr_rd_path.sv
// One read port: bank select, forwarding capture, output mux/merge, hold
// register, optional extra output stage and valid tracking.
module sram_b_rd_path
    import sram_b_pkg::*;
#(
    parameter int ABITS   = 16,
    parameter int DBITS   = 8,
    parameter int NV      = 4,
    parameter int VBITS   = 2,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                ce_i,
    input  logic                oor_i,
    input  logic [ABITS-1:0]    addr_i,
    input  logic                wr_i,
    input  logic [ABITS-1:0]    wr_addr_i,
    input  logic [DBITS-1:0]    wr_data_i,
    input  logic [DBITS-1:0]    wr_mask_i,
    input  logic [NV*DBITS-1:0] bank_q_i,
    output logic [DBITS-1:0]    q_o,
    output logic                valid_o
);
    logic             rd_q;
    logic             oor_q;
    logic             hit_q;
    logic [VBITS-1:0] vsel_q;
    logic [DBITS-1:0] byp_data_q;
    logic [DBITS-1:0] byp_mask_q;
    logic [DBITS-1:0] hold_q;
    logic [DBITS-1:0] raw_s;
    logic [DBITS-1:0] data_s;
    logic [DBITS-1:0] hold_d;

    // Request-side capture on the CE_R edge; select/bypass terms only move on a read
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_q       <= 1'b0;
            oor_q      <= 1'b0;
            hit_q      <= 1'b0;
            vsel_q     <= '0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
            hold_q     <= '0;
        end else begin
            rd_q   <= ce_i;
            hold_q <= hold_d;
            if (ce_i) begin
                vsel_q     <= addr_i[ABITS-1 -: VBITS];
                oor_q      <= oor_i;
                hit_q      <= (BYPASS != 0) && wr_i && (wr_addr_i == addr_i);
                byp_data_q <= wr_data_i;
                byp_mask_q <= wr_mask_i;
            end
        end
    end

    // Bank mux, forwarding merge, out-of-range squash and hold selection
    always_comb begin
        raw_s = '0;
        for (int v = 0; v < NV; v++) begin
            if (vsel_q == VBITS'(v)) begin
                raw_s = bank_q_i[v*DBITS +: DBITS];
            end else begin
                raw_s = raw_s;
            end
        end
        if (oor_q) begin
            data_s = '0;
        end else if (hit_q) begin
            data_s = DBITS'(bypass_merge(MAXW'(byp_data_q), MAXW'(byp_mask_q), MAXW'(raw_s)));
        end else begin
            data_s = raw_s;
        end
        if (rd_q) begin
            hold_d = data_s;
        end else begin
            hold_d = hold_q;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DBITS-1:0] q_out_q;
        logic             valid_out_q;

        // Extra pipeline stage; takes a new word every cycle so reads stream
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                q_out_q     <= '0;
                valid_out_q <= 1'b0;
            end else begin
                q_out_q     <= hold_d;
                valid_out_q <= rd_q;
            end
        end

        assign q_o     = q_out_q;
        assign valid_o = valid_out_q;
    end else begin : g_noreg
        assign q_o     = hold_d;
        assign valid_o = rd_q;
    end

endmodule

// File: rtl/sram_b_param_1w_nr.sv
// Banked 1-write / NRD-read SRAM wrapper: write fan-out to per-port duplicated
// bank sets, BRAM bank array, per-port read paths and the sticky range error.
module sram_b_param_1w_nr
    import sram_b_pkg::*;
#(
    parameter int ABITS      = 16,
    parameter int DBITS      = 8,
    parameter int DEPTH      = 65536,
    parameter int NRD        = 2,
    parameter int BANK_ABITS = 14,
    parameter int BANK_DBITS = 1,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
) (
    input logic                 CLK,
    input logic                 RSTN,
    sram_b_param_1w_nr_if.slave bus
);
    localparam int NV    = ceil_div(DEPTH, 2 ** BANK_ABITS);
    localparam int NH    = ceil_div(DBITS, BANK_DBITS);
    localparam int VBITS = ABITS - BANK_ABITS;
    localparam int PBITS = NH * BANK_DBITS;

    logic                 wr_s;
    logic                 wr_oor_s;
    logic [VBITS-1:0]     wr_vb_s;
    logic [PBITS-1:0]     wd_pad_s;
    logic [PBITS-1:0]     wm_pad_s;
    logic [NRD-1:0]       rd_oor_s;
    logic [NRD*DBITS-1:0] q_all_s;
    logic [NRD-1:0]       valid_s;
    logic                 err_d;
    logic                 err_q;

    // Write qualification, padding to whole horizontal banks, and error next-state
    always_comb begin
        wr_s     = bus.CE0 && bus.WE0 && (32'(bus.A0) < DEPTH);
        wr_oor_s = bus.CE0 && bus.WE0 && !(32'(bus.A0) < DEPTH);
        wr_vb_s  = bus.A0[ABITS-1:BANK_ABITS];
        wd_pad_s = PBITS'(bus.D0);
        wm_pad_s = PBITS'(bus.WEM0);
        err_d    = err_q || wr_oor_s || (|rd_oor_s);
    end

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_port
        logic [ABITS-1:0]    ra_s;
        logic                re_s;
        logic [NV*DBITS-1:0] bank_q_s;

        assign ra_s        = bus.A_R[r*ABITS +: ABITS];
        assign re_s        = bus.CE_R[r] && (32'(ra_s) < DEPTH);
        assign rd_oor_s[r] = bus.CE_R[r] && !(32'(ra_s) < DEPTH);

        for (genvar v = 0; v < NV; v++) begin : g_vert
            logic [PBITS-1:0] row_q;

            for (genvar h = 0; h < NH; h++) begin : g_horz
                logic [BANK_DBITS-1:0] mem [2 ** BANK_ABITS];
                logic [BANK_DBITS-1:0] dout_q;

                // BRAM primitive: unreset contents, bit-masked write, read-first output
                always_ff @(posedge CLK) begin
                    if (wr_s && (wr_vb_s == VBITS'(v))) begin
                        for (int b = 0; b < BANK_DBITS; b++) begin
                            if (wm_pad_s[h*BANK_DBITS+b]) begin
                                mem[bus.A0[BANK_ABITS-1:0]][b] <= wd_pad_s[h*BANK_DBITS+b];
                            end
                        end
                    end
                    if (re_s && (ra_s[ABITS-1:BANK_ABITS] == VBITS'(v))) begin
                        dout_q <= mem[ra_s[BANK_ABITS-1:0]];
                    end
                end

                assign row_q[h*BANK_DBITS +: BANK_DBITS] = dout_q;
            end

            assign bank_q_s[v*DBITS +: DBITS] = row_q[DBITS-1:0];
        end

        sram_b_rd_path #(
            .ABITS   (ABITS),
            .DBITS   (DBITS),
            .NV      (NV),
            .VBITS   (VBITS),
            .OUT_REG (OUT_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .CLK       (CLK),
            .RSTN      (RSTN),
            .ce_i      (bus.CE_R[r]),
            .oor_i     (rd_oor_s[r]),
            .addr_i    (ra_s),
            .wr_i      (wr_s),
            .wr_addr_i (bus.A0),
            .wr_data_i (bus.D0),
            .wr_mask_i (bus.WEM0),
            .bank_q_i  (bank_q_s),
            .q_o       (q_all_s[r*DBITS +: DBITS]),
            .valid_o   (valid_s[r])
        );
    end

    if (BYPASS == 0) begin : g_chk
        sram_b_chk #(
            .ABITS (ABITS),
            .NRD   (NRD)
        ) u_chk (
            .CLK       (CLK),
            .RSTN      (RSTN),
            .wr_i      (wr_s),
            .wr_addr_i (bus.A0),
            .ce_r_i    (bus.CE_R),
            .a_r_i     (bus.A_R)
        );
    end

    assign bus.Q_R     = q_all_s;
    assign bus.VALID_R = valid_s;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_sram_b_param_1w_nr.sv
// Directed vector table, reset/hold sequences and a randomized phase checked
// against an array-based memory model with a per-port latency queue.
module tb_sram_b_param_1w_nr;
    localparam int ABITS   = 16;
    localparam int DBITS   = 8;
    localparam int DEPTH   = 40000;
    localparam int NRD     = 2;
    localparam int OUT_REG = 0;
    localparam int LAT     = 1 + OUT_REG;
    localparam int NVEC    = 15;

    logic CLK;
    logic RSTN;

    sram_b_param_1w_nr_if #(.ABITS(ABITS), .DBITS(DBITS), .NRD(NRD)) bus ();

    sram_b_param_1w_nr #(
        .ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH), .NRD(NRD),
        .BANK_ABITS(14), .BANK_DBITS(1), .OUT_REG(OUT_REG), .BYPASS(1)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ce0;
        logic        we0;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [7:0]  wem0;
        logic [1:0]  ce_r;
        logic [15:0] ar0;
        logic [15:0] ar1;
        logic [7:0]  q0;
        logic [7:0]  q1;
        logic [1:0]  v;
        logic        err;
    } vec_t;

    vec_t        tbl [NVEC];
    logic [7:0]  ref_mem [0:65535];
    logic [8:0]  pipe [NRD][$];
    logic [7:0]  exp_q [NRD];
    logic [1:0]  exp_v;
    logic        m_err;
    logic [15:0] pool [12];
    int          checks;
    int          failures;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NRD; r++) begin
            pipe[r].delete();
            exp_q[r] = 8'h00;
        end
        exp_v = 2'b00;
        m_err = 1'b0;
    endtask

    // Drive one cycle, advance the model, and leave exp_* describing the outputs after the edge
    task automatic step(input logic ce0, input logic we0, input logic [15:0] a0,
                        input logic [7:0] d0, input logic [7:0] wem0,
                        input logic [1:0] ce_r, input logic [15:0] ar0, input logic [15:0] ar1);
        logic        wr;
        logic [15:0] ar [NRD];
        logic [7:0]  val;
        logic [8:0]  e;
        ar[0] = ar0;
        ar[1] = ar1;
        bus.CE0  = ce0;
        bus.WE0  = we0;
        bus.A0   = a0;
        bus.D0   = d0;
        bus.WEM0 = wem0;
        bus.CE_R = ce_r;
        bus.A_R  = {ar1, ar0};
        wr = ce0 && we0 && (32'(a0) < DEPTH);
        for (int r = 0; r < NRD; r++) begin
            if (ce_r[r]) begin
                if (32'(ar[r]) >= DEPTH) begin
                    val   = 8'h00;
                    m_err = 1'b1;
                end else if (wr && (ar[r] == a0)) begin
                    val = (d0 & wem0) | (ref_mem[ar[r]] & ~wem0);
                end else begin
                    val = ref_mem[ar[r]];
                end
                pipe[r].push_back({1'b1, val});
            end else begin
                pipe[r].push_back(9'h000);
            end
        end
        if (wr) ref_mem[a0] = (d0 & wem0) | (ref_mem[a0] & ~wem0);
        else if (ce0 && we0) m_err = 1'b1;
        @(posedge CLK);
        #1;
        for (int r = 0; r < NRD; r++) begin
            if (pipe[r].size() >= LAT) begin
                e = pipe[r].pop_front();
                exp_v[r] = e[8];
                if (e[8]) exp_q[r] = e[7:0];
            end else begin
                exp_v[r] = 1'b0;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        RSTN     = 1'b0;
        bus.CE0  = 1'b0;
        bus.WE0  = 1'b0;
        bus.A0   = 16'h0000;
        bus.D0   = 8'h00;
        bus.WEM0 = 8'h00;
        bus.CE_R = 2'b00;
        bus.A_R  = 32'h0000_0000;

        //        ce0   we0   a0        d0     wem0   ce_r   ar0       ar1       q0     q1     v      err
        tbl[0]  = '{1'b1, 1'b1, 16'h0000, 8'hA5, 8'hFF, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b01, 16'h0000, 16'h0000, 8'hA5, 8'h00, 2'b01, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h4001, 8'hFF, 8'hFF, 2'b00, 16'h0000, 16'h0000, 8'hA5, 8'h00, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h4001, 8'h00, 8'h0F, 2'b00, 16'h0000, 16'h0000, 8'hA5, 8'h00, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b11, 16'h4001, 16'h4001, 8'hF0, 8'hF0, 2'b11, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h7FFF, 8'h3C, 8'hFF, 2'b11, 16'h7FFF, 16'h7FFF, 8'h3C, 8'h3C, 2'b11, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h7FFF, 8'hC3, 8'hF0, 2'b11, 16'h7FFF, 16'h0000, 8'hCC, 8'hA5, 2'b11, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'h1234, 8'h5A, 8'hFF, 2'b00, 16'h0000, 16'h0000, 8'hCC, 8'hA5, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'h1C40, 8'h11, 8'hFF, 2'b00, 16'h0000, 16'h0000, 8'hCC, 8'hA5, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b01, 16'h1234, 16'h0000, 8'h5A, 8'hA5, 2'b01, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b10, 16'h0000, 16'h9C40, 8'h5A, 8'h00, 2'b10, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 16'h9C40, 8'h77, 8'hFF, 2'b01, 16'h1C40, 16'h0000, 8'h11, 8'h00, 2'b01, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b11, 16'h9C40, 16'h1234, 8'h00, 8'h5A, 2'b11, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b01, 16'h1234, 16'h0000, 8'h5A, 8'h5A, 2'b01, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hFF, 2'b10, 16'h0000, 16'h1234, 8'h5A, 8'h5A, 2'b10, 1'b1};

        pool = '{16'h0000, 16'h0001, 16'h3FFF, 16'h4000, 16'h4001, 16'h7FFF,
                 16'h8000, 16'h9C3F, 16'h1234, 16'h1C40, 16'h9C40, 16'hFFFF};

        repeat (3) @(posedge CLK);
        #1;
        check("reset_q", 32'(bus.Q_R), 32'h0);
        check("reset_valid", 32'(bus.VALID_R), 32'h0);
        check("reset_err", 32'(bus.ERR), 32'h0);
        @(negedge CLK);
        RSTN = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].ce0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].wem0,
                 tbl[i].ce_r, tbl[i].ar0, tbl[i].ar1);
            check($sformatf("tbl%0d_q0", i), 32'(bus.Q_R[7:0]), 32'(tbl[i].q0));
            check($sformatf("tbl%0d_q1", i), 32'(bus.Q_R[15:8]), 32'(tbl[i].q1));
            check($sformatf("tbl%0d_valid", i), 32'(bus.VALID_R), 32'(tbl[i].v));
            check($sformatf("tbl%0d_err", i), 32'(bus.ERR), 32'(tbl[i].err));
        end

        // Ten idle cycles: both ports hold 0x5A, no valid pulses, error stays set
        for (int i = 0; i < 10; i++) begin
            idle();
            check($sformatf("hold%0d_q0", i), 32'(bus.Q_R[7:0]), 32'h5A);
            check($sformatf("hold%0d_valid", i), 32'(bus.VALID_R), 32'h0);
        end
        check("hold_err", 32'(bus.ERR), 32'h1);

        // Reset asserted while a read enable is presented in the same cycle
        bus.CE0  = 1'b0;
        bus.WE0  = 1'b0;
        bus.CE_R = 2'b01;
        bus.A_R  = {16'h0000, 16'h4001};
        #2;
        RSTN = 1'b0;
        #1;
        check("rst_async_q", 32'(bus.Q_R), 32'h0);
        @(posedge CLK);
        #1;
        check("rst_q", 32'(bus.Q_R), 32'h0);
        check("rst_valid", 32'(bus.VALID_R), 32'h0);
        check("rst_err", 32'(bus.ERR), 32'h0);
        bus.CE_R = 2'b00;
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        idle();
        check("post_rst_valid", 32'(bus.VALID_R), 32'h0);
        check("post_rst_q", 32'(bus.Q_R), 32'h0);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b11, 16'h4001, 16'h0000);
        check("post_rst_rd_q0", 32'(bus.Q_R[7:0]), 32'hF0);
        check("post_rst_rd_q1", 32'(bus.Q_R[15:8]), 32'hA5);
        check("post_rst_rd_valid", 32'(bus.VALID_R), 32'h3);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, pool[i], 8'($urandom_range(255)), 8'hFF, 2'b00, 16'h0000, 16'h0000);
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), pool[$urandom_range(11)],
                 8'($urandom_range(255)), 8'($urandom_range(255)), 2'($urandom_range(3)),
                 pool[$urandom_range(11)], pool[$urandom_range(11)]);
            check($sformatf("rnd%0d_q0", i), 32'(bus.Q_R[7:0]), 32'(exp_q[0]));
            check($sformatf("rnd%0d_q1", i), 32'(bus.Q_R[15:8]), 32'(exp_q[1]));
            check($sformatf("rnd%0d_valid", i), 32'(bus.VALID_R), 32'(exp_v));
            check($sformatf("rnd%0d_err", i), 32'(bus.ERR), 32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
